demux_1_2_packet_scheduler: RTL and testbench
=============================================

// Module: demux_1_2_packet_scheduler
// PURPOSE
//  Packet-level controller for the 1:2 DEMUX path. Accepts a valid/ready input stream, picks a
//  destination per packet (from a tag or by round-robin) and locks it until the packet's last
//  beat. Drives two registered valid/ready output channels. Sits between a packet source and two
//  downstream consumers in place of a bare combinational DEMUX.
// PARAMETERS
//  DATA_WIDTH  8  width of each data beat
//  CNT_WIDTH   8  width of per-channel completed-packet counters (wrap modulo 2^CNT_WIDTH)
// PORTS
//  Clock_In            in   1           single clock, all state updates on rising edge
//  Reset_In            in   1           synchronous, active-high reset
//  Enable_In           in   1           1 = accept input beats; 0 = stall input (outputs still drain)
//  Mode_In             in   1           0 = route by Dest_In tag, 1 = round-robin per packet
//  Valid_In            in   1           input beat valid
//  Data_In             in   DATA_WIDTH  input beat data
//  Dest_In             in   1           destination tag, sampled on a packet's first beat only
//  Last_In             in   1           marks final beat of packet
//  Ready_Out           out  1           input beat accepted when Valid_In & Ready_Out
//  Data_0_Out          out  DATA_WIDTH  channel 0 data (registered)
//  Valid_0_Out         out  1           channel 0 valid
//  Ready_0_In          in   1           channel 0 consumer ready
//  Data_1_Out          out  DATA_WIDTH  channel 1 data (registered)
//  Valid_1_Out         out  1           channel 1 valid
//  Ready_1_In          in   1           channel 1 consumer ready
//  Select_Out          out  1           current/next route (locked channel, else candidate)
//  Busy_Out            out  1           1 while a packet is open (state != IDLE)
//  Packet_Count_0_Out  out  CNT_WIDTH   packets completed to channel 0
//  Packet_Count_1_Out  out  CNT_WIDTH   packets completed to channel 1
// BEHAVIOUR
//  - Reset: state IDLE, rr pointer 0, Valid_x_Out 0, Data_x_Out 0, counters 0, Busy_Out 0.
//    Reset mid-packet discards the open packet and any held output beats.
//  - States: IDLE, LOCK_0, LOCK_1. Candidate in IDLE = Mode_In ? rr_ptr : Dest_In; in LOCK_x = x.
//  - Ready_Out = Enable_In & (~Valid_t_Out | Ready_t_In), t = candidate. Combinational, no
//    dependency on Valid_In.
//  - IDLE, accepted beat, Last_In=0 -> LOCK_t. Last_In=1 -> single-beat packet, stay IDLE.
//  - LOCK_x: Dest_In and Mode_In ignored; accepted beat with Last_In=1 -> IDLE.
//  - On accepted last beat to t: Packet_Count_t += 1 (wraps), rr_ptr <= ~t (both modes).
//  - Output stage x: load on accept to x -> Valid_x_Out=1 next cycle, Data_x_Out=beat (1-cycle
//    latency). Clear when Valid_x_Out & Ready_x_In and no load same cycle. Simultaneous drain+load
//    keeps valid high with new data (full throughput). Data stable while Valid & ~Ready.
//  - Channel not targeted never changes; its held beat drains independently.
//  - Enable_In=0 mid-packet: Ready_Out=0, state/lock held, outputs continue draining.
//  - Mode_In sampled only in IDLE; changing it mid-packet has no effect until next packet.
//  - Valid_In=0 bubbles inside a packet are legal; lock holds indefinitely.
// STRUCTURE
//  - Package demux_ctrl_pkg: state_t enum {IDLE, LOCK_0, LOCK_1}; DEST_0/DEST_1 constants;
//    MODE_TAG/MODE_RR constants.
//  - Sub-module demux_out_stage (one-entry valid/ready register), instantiated twice.
//  - Top holds FSM, rr pointer, candidate/Ready_Out logic and counters.
// TESTING
//  - Reset: assert Reset_In 2 cycles with Valid_In=1 -> all outputs 0, Ready_Out=Enable_In.
//  - Tag mode, 3-beat packet Dest_In=1 data A1,A2,A3, Ready_1_In=1 -> Data_1_Out A1..A3 one cycle
//    later, Valid_0_Out stays 0, Packet_Count_1_Out=1.
//  - Dest_In toggled to 0 on beat 2 of a packet locked to 1 -> all beats still on channel 1.
//  - RR mode, four 1-beat packets -> channels 0,1,0,1; counters 2 and 2.
//  - Backpressure: Ready_0_In=0 with beat held -> Ready_Out=0, Data_0_Out stable; release ->
//    beat drains, next beat accepted same cycle (no bubble).
//  - Enable_In=0 for 5 cycles mid-packet, then Reset_In mid-packet -> no beats accepted while
//    disabled; after reset state IDLE, counters 0, next packet routes per fresh rr_ptr=0.

Source files
------------

// File: rtl/demux_ctrl_pkg.sv
// Shared types and constants for the 1:2 packet demux controller.
package demux_ctrl_pkg;

  // Packet FSM: idle between packets, or locked to one output channel.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_0 = 2'd1,
    LOCK_1 = 2'd2
  } state_t;

  localparam logic DEST_0   = 1'b0;
  localparam logic DEST_1   = 1'b1;

  localparam logic MODE_TAG = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Lock state that pins a packet to channel t.
  function automatic state_t lock_state(logic t);
    return (t == DEST_1) ? LOCK_1 : LOCK_0;
  endfunction

endpackage

// File: rtl/demux_out_stage.sv
// One-entry valid/ready output register. A load always wins over a drain, so a
// drain and a load in the same cycle keep valid high with the new beat.
module demux_out_stage #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Next-state: load takes priority; otherwise clear once the consumer takes the beat.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Holding register with synchronous reset that discards any pending beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/demux_1_2_packet_scheduler.sv
// Packet-level 1:2 demux controller. Picks a destination per packet (tag or
// round-robin), locks it until the last beat and feeds two registered outputs.
module demux_1_2_packet_scheduler
  import demux_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  Clock_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic                  Mode_In,
  input  logic                  Valid_In,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Dest_In,
  input  logic                  Last_In,
  output logic                  Ready_Out,
  output logic [DATA_WIDTH-1:0] Data_0_Out,
  output logic                  Valid_0_Out,
  input  logic                  Ready_0_In,
  output logic [DATA_WIDTH-1:0] Data_1_Out,
  output logic                  Valid_1_Out,
  input  logic                  Ready_1_In,
  output logic                  Select_Out,
  output logic                  Busy_Out,
  output logic [CNT_WIDTH-1:0]  Packet_Count_0_Out,
  output logic [CNT_WIDTH-1:0]  Packet_Count_1_Out
);

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic                 rr_q, rr_d;
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;

  logic cand;
  logic cand_free;
  logic accept;
  logic accept_last;
  logic load0, load1;

  // Route candidate: the locked channel mid-packet, else tag or rr pointer.
  always_comb begin
    cand = DEST_0;
    unique case (state_q)
      IDLE:    cand = (Mode_In == MODE_RR) ? rr_q : Dest_In;
      LOCK_0:  cand = DEST_0;
      LOCK_1:  cand = DEST_1;
      default: cand = DEST_0;
    endcase
  end

  // Input ready only looks at the candidate stage, never at Valid_In.
  always_comb begin
    cand_free = (cand == DEST_1) ? (~Valid_1_Out | Ready_1_In)
                                 : (~Valid_0_Out | Ready_0_In);
  end

  assign Ready_Out   = Enable_In & cand_free;
  assign accept      = Valid_In & Ready_Out;
  assign accept_last = accept & Last_In;
  assign load0       = accept & (cand == DEST_0);
  assign load1       = accept & (cand == DEST_1);

  // FSM, round-robin pointer and per-channel completion counters.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    if (accept) begin
      if (Last_In) begin
        state_d = IDLE;
      end else if (state_q == IDLE) begin
        state_d = lock_state(cand);
      end
    end
    if (accept_last) begin
      rr_d = ~cand;
      if (cand == DEST_1) begin
        cnt1_d = cnt1_q + CntOne;
      end else begin
        cnt0_d = cnt0_q + CntOne;
      end
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
      rr_q    <= DEST_0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  demux_out_stage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_stage_0 (
    .clk_i  (Clock_In),
    .rst_i  (Reset_In),
    .load_i (load0),
    .data_i (Data_In),
    .ready_i(Ready_0_In),
    .valid_o(Valid_0_Out),
    .data_o (Data_0_Out)
  );

  demux_out_stage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_stage_1 (
    .clk_i  (Clock_In),
    .rst_i  (Reset_In),
    .load_i (load1),
    .data_i (Data_In),
    .ready_i(Ready_1_In),
    .valid_o(Valid_1_Out),
    .data_o (Data_1_Out)
  );

  assign Select_Out         = cand;
  assign Busy_Out           = (state_q != IDLE);
  assign Packet_Count_0_Out = cnt0_q;
  assign Packet_Count_1_Out = cnt1_q;

endmodule

// File: tb/tb_demux_1_2_packet_scheduler.sv
// Scoreboard bench: the driver keeps a packet-level model and pushes every
// accepted beat onto its channel's expected queue; the monitor pops on drain.
module tb_demux_1_2_packet_scheduler;

  logic       Clock_In = 1'b0;
  logic       Reset_In = 1'b0;
  logic       Enable_In = 1'b0;
  logic       Mode_In = 1'b0;
  logic       Valid_In = 1'b0;
  logic [7:0] Data_In = '0;
  logic       Dest_In = 1'b0;
  logic       Last_In = 1'b0;
  logic       Ready_Out;
  logic [7:0] Data_0_Out;
  logic       Valid_0_Out;
  logic       Ready_0_In = 1'b0;
  logic [7:0] Data_1_Out;
  logic       Valid_1_Out;
  logic       Ready_1_In = 1'b0;
  logic       Select_Out;
  logic       Busy_Out;
  logic [7:0] Packet_Count_0_Out;
  logic [7:0] Packet_Count_1_Out;

  int checks = 0;
  int errors = 0;

  // Packet-level reference model.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         m_open;
  bit         m_lock;
  bit         m_rr;
  logic [7:0] m_cnt0;
  logic [7:0] m_cnt1;
  bit         prev_rst;

  demux_1_2_packet_scheduler #(
    .DATA_WIDTH(8),
    .CNT_WIDTH (8)
  ) dut (
    .Clock_In          (Clock_In),
    .Reset_In          (Reset_In),
    .Enable_In         (Enable_In),
    .Mode_In           (Mode_In),
    .Valid_In          (Valid_In),
    .Data_In           (Data_In),
    .Dest_In           (Dest_In),
    .Last_In           (Last_In),
    .Ready_Out         (Ready_Out),
    .Data_0_Out        (Data_0_Out),
    .Valid_0_Out       (Valid_0_Out),
    .Ready_0_In        (Ready_0_In),
    .Data_1_Out        (Data_1_Out),
    .Valid_1_Out       (Valid_1_Out),
    .Ready_1_In        (Ready_1_In),
    .Select_Out        (Select_Out),
    .Busy_Out          (Busy_Out),
    .Packet_Count_0_Out(Packet_Count_0_Out),
    .Packet_Count_1_Out(Packet_Count_1_Out)
  );

  always #5 Clock_In = ~Clock_In;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: runs 3 time units after each edge, before the driver's model step.
  initial begin
    forever begin
      @(posedge Clock_In);
      #3;
      if (!Reset_In) begin
        check("valid0", Valid_0_Out, (q0.size() != 0));
        if (Valid_0_Out && q0.size() != 0) begin
          check("data0", Data_0_Out, q0[0]);
          if (Ready_0_In) void'(q0.pop_front());
        end
        check("valid1", Valid_1_Out, (q1.size() != 0));
        if (Valid_1_Out && q1.size() != 0) begin
          check("data1", Data_1_Out, q1[0]);
          if (Ready_1_In) void'(q1.pop_front());
        end
      end
    end
  end

  // One cycle of stimulus followed by the model step for the upcoming edge.
  task automatic cyc(input bit rst, input bit en, input bit mode, input bit vld,
                     input logic [7:0] data, input bit dest, input bit last,
                     input bit r0, input bit r1);
    bit t;
    bit exp_rdy;
    @(posedge Clock_In);
    #2;
    Reset_In = rst; Enable_In = en; Mode_In = mode; Valid_In = vld;
    Data_In = data; Dest_In = dest; Last_In = last;
    Ready_0_In = r0; Ready_1_In = r1;
    #2;
    if (rst) begin
      if (prev_rst) begin
        check("rst_valid0", Valid_0_Out, 1'b0);
        check("rst_valid1", Valid_1_Out, 1'b0);
        check("rst_data0", Data_0_Out, 8'h00);
        check("rst_data1", Data_1_Out, 8'h00);
        check("rst_cnt0", Packet_Count_0_Out, 8'h00);
        check("rst_cnt1", Packet_Count_1_Out, 8'h00);
        check("rst_busy", Busy_Out, 1'b0);
        check("rst_ready", Ready_Out, en);
      end
      q0.delete(); q1.delete();
      m_open = 1'b0; m_lock = 1'b0; m_rr = 1'b0;
      m_cnt0 = '0; m_cnt1 = '0;
      prev_rst = 1'b1;
      return;
    end
    prev_rst = 1'b0;
    t = m_open ? m_lock : (mode ? m_rr : dest);
    exp_rdy = en && ((t ? q1.size() : q0.size()) == 0 || (t ? r1 : r0));
    check("ready_out", Ready_Out, exp_rdy);
    check("select", Select_Out, t);
    check("busy", Busy_Out, m_open);
    check("cnt0", Packet_Count_0_Out, m_cnt0);
    check("cnt1", Packet_Count_1_Out, m_cnt1);
    if (vld && exp_rdy) begin
      if (t) q1.push_back(data);
      else   q0.push_back(data);
      if (last) begin
        if (t) m_cnt1 = m_cnt1 + 8'd1;
        else   m_cnt0 = m_cnt0 + 8'd1;
        m_rr   = ~t;
        m_open = 1'b0;
      end else begin
        m_open = 1'b1;
        m_lock = t;
      end
    end
  endtask

  initial begin
    // Reset with Valid_In high.
    cyc(1, 1, 0, 1, 8'h55, 1, 0, 1, 1);
    cyc(1, 1, 0, 1, 8'h55, 1, 0, 1, 1);
    cyc(1, 0, 0, 1, 8'h55, 1, 0, 1, 1);

    // Tag mode, 3-beat packet to channel 1; tag flips mid-packet.
    cyc(0, 1, 0, 1, 8'hA1, 1, 0, 1, 1);
    cyc(0, 1, 0, 1, 8'hA2, 0, 0, 1, 1);
    cyc(0, 1, 0, 1, 8'hA3, 0, 1, 1, 1);
    cyc(0, 1, 0, 0, 8'h00, 0, 0, 1, 1);
    cyc(0, 1, 0, 0, 8'h00, 0, 0, 1, 1);

    // Round-robin, four single-beat packets.
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 1, 8'hB0 + 8'(i), 1, 1, 1, 1);
    cyc(0, 1, 1, 0, 8'h00, 0, 0, 1, 1);
    cyc(0, 1, 1, 0, 8'h00, 0, 0, 1, 1);

    // Backpressure on channel 0, then release with a beat waiting.
    cyc(0, 1, 0, 1, 8'hC1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, 8'hC2, 0, 0, 0, 1);
    cyc(0, 1, 0, 1, 8'hC2, 0, 1, 1, 1);
    cyc(0, 1, 0, 0, 8'h00, 0, 0, 1, 1);

    // Disable mid-packet, then reset mid-packet; next RR packet goes to 0.
    cyc(0, 1, 0, 1, 8'hD1, 1, 0, 1, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 8'hD2, 1, 0, 1, 1);
    cyc(1, 1, 0, 1, 8'hD3, 1, 0, 1, 1);
    cyc(1, 1, 0, 1, 8'hD3, 1, 0, 1, 1);
    cyc(0, 1, 1, 1, 8'hE1, 1, 1, 1, 1);
    cyc(0, 1, 1, 0, 8'h00, 1, 0, 1, 1);

    // Randomized traffic with random backpressure, bubbles and mode flips.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) != 0), 1'($urandom),
          ($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 2) != 0));
    end

    // Drain.
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 8'h00, 0, 0, 1, 1);
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
